// File: rtl/dm_sig_monitor_if.sv
// Bus bundle for dm_sig_monitor: snooped CPU data-memory writes, the dump read port
// and the ready/valid dump stream. The monitor uses the master side.
interface dm_sig_monitor_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_idx;
  logic [DATA_W-1:0] dump_data;

  modport master (
    input  dm_we, dm_addr, dm_wdata, rd_data, dump_ready,
    output rd_en, rd_addr, dump_valid, dump_idx, dump_data
  );

  modport slave (
    output dm_we, dm_addr, dm_wdata, rd_data, dump_ready,
    input  rd_en, rd_addr, dump_valid, dump_idx, dump_data
  );
endinterface

// File: rtl/dm_sig_monitor.sv
// Watches CPU data-memory writes for a completion signature, then halts the CPU and
// streams a window of data memory out over a ready/valid port; times out otherwise.
module dm_sig_monitor #(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 10,
  parameter int unsigned       SIG_ADDR   = 20,
  parameter logic [DATA_W-1:0] SIG_VALUE  = 32'hABCD0000,
  parameter int unsigned       DUMP_BASE  = 0,
  parameter int unsigned       DUMP_COUNT = 20,
  parameter int unsigned       TIMEOUT    = 100000,
  parameter int                CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  dm_sig_monitor_if.master     bus,
  input  logic [31:0]          pc,
  output logic                 halt,
  output logic                 done,
  output logic                 pass,
  output logic                 timed_out,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     instr_cnt
);

  typedef enum logic [2:0] {
    ARMED,
    READ,
    WAIT,
    PRESENT,
    DONE
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] next_idx;
  logic [31:0]       pc_q;
  logic              hit;
  logic              timeout_hit;
  logic              last_word;
  logic              set_pass;
  logic              set_timeout;

  assign hit         = bus.dm_we && (bus.dm_addr == ADDR_W'(SIG_ADDR)) && (bus.dm_wdata == SIG_VALUE);
  assign timeout_hit = (TIMEOUT != 0) && (cycle_cnt == CNT_W'(TIMEOUT - 1));
  assign last_word   = (idx == ADDR_W'(DUMP_COUNT - 1));

  assign halt = (state != ARMED);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ARMED;
      idx           <= '0;
      pc_q          <= '0;
      cycle_cnt     <= '0;
      instr_cnt     <= '0;
      bus.dump_data <= '0;
      bus.dump_idx  <= '0;
      pass          <= 1'b0;
      timed_out     <= 1'b0;
    end else begin
      state <= next_state;
      idx   <= next_idx;
      pc_q  <= pc;
      // Counters only run while armed, so they freeze from the first cycle after a hit or timeout.
      if (state == ARMED) begin
        if (cycle_cnt != '1) begin
          cycle_cnt <= cycle_cnt + CNT_W'(1);
        end
        if ((pc != pc_q) && (instr_cnt != '1)) begin
          instr_cnt <= instr_cnt + CNT_W'(1);
        end
      end
      if (state == WAIT) begin
        bus.dump_data <= bus.rd_data;
        bus.dump_idx  <= idx;
      end
      if (set_pass) begin
        pass <= 1'b1;
      end
      if (set_timeout) begin
        timed_out <= 1'b1;
      end
    end
  end

  always_comb begin
    next_state     = state;
    next_idx       = idx;
    bus.rd_en      = 1'b0;
    bus.rd_addr    = '0;
    bus.dump_valid = 1'b0;
    set_pass       = 1'b0;
    set_timeout    = 1'b0;
    unique case (state)
      ARMED: begin
        // A hit outranks a timeout landing on the same cycle.
        if (hit) begin
          next_idx = '0;
          if (DUMP_COUNT == 0) begin
            next_state = DONE;
            set_pass   = 1'b1;
          end else begin
            next_state = READ;
          end
        end else if (timeout_hit) begin
          next_state  = DONE;
          set_timeout = 1'b1;
        end
      end
      READ: begin
        bus.rd_en   = 1'b1;
        bus.rd_addr = ADDR_W'(DUMP_BASE) + idx;
        next_state  = WAIT;
      end
      WAIT: begin
        next_state = PRESENT;
      end
      PRESENT: begin
        bus.dump_valid = 1'b1;
        if (bus.dump_ready) begin
          if (last_word) begin
            next_state = DONE;
            set_pass   = 1'b1;
          end else begin
            next_idx   = idx + ADDR_W'(1);
            next_state = READ;
          end
        end
      end
      DONE: begin
        next_state = DONE;
      end
      default: begin
        next_state = ARMED;
      end
    endcase
  end

endmodule

// File: doc/dm_sig_monitor.md
DM_SIG_MONITOR -- requirements
Module: dm_sig_monitor

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_W, 32, data-memory word width.
- ADDR_W, 10, data-memory word-address width.
- SIG_ADDR, 20, word address watched for the completion signature.
- SIG_VALUE, 32'hABCD0000, completion signature value.
- DUMP_BASE, 0, first word address dumped.
- DUMP_COUNT, 20, number of words dumped (0 allowed).
- TIMEOUT, 100000, cycle limit before a fail (0 disables).
- CNT_W, 32, width of the performance counters.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, synchronous active-high reset.
- dm_we, in, 1, CPU data-memory write strobe (snooped).
- dm_addr, in, ADDR_W, CPU data-memory word address (snooped).
- dm_wdata, in, DATA_W, CPU data-memory write data (snooped).
- pc, in, 32, CPU program counter (snooped).
- rd_en, out, 1, dump read request to data-memory read port.
- rd_addr, out, ADDR_W, dump read address.
- rd_data, in, DATA_W, read data, valid the cycle after rd_en.
- dump_valid, out, 1, dump word available.
- dump_ready, in, 1, consumer accepts dump word.
- dump_idx, out, ADDR_W, index of the presented word (0..DUMP_COUNT-1).
- dump_data, out, DATA_W, presented word.
- halt, out, 1, request to freeze the CPU.
- done, out, 1, run finished (pass or timeout).
- pass, out, 1, signature seen and dump complete.
- timed_out, out, 1, TIMEOUT reached without a signature.
- cycle_cnt, out, CNT_W, cycles spent in ARMED.
- instr_cnt, out, CNT_W, PC changes observed in ARMED.

Function
REQ-003 The FSM SHALL have states ARMED, READ, WAIT, PRESENT and DONE; ARMED is the reset state.
REQ-004 In ARMED: cycle_cnt SHALL increment every cycle, saturating at all-ones; instr_cnt SHALL increment in each cycle where pc differs from its registered previous value pc_q, saturating. pc_q resets to 0.
REQ-005 A hit SHALL be defined as dm_we=1, dm_addr=SIG_ADDR and dm_wdata=SIG_VALUE, all sampled in ARMED.
REQ-006 On a hit, the next state SHALL be READ with idx=0. Both counters freeze. halt=1 from the next cycle until rst.
REQ-007 When TIMEOUT!=0 and cycle_cnt equals TIMEOUT-1 in ARMED with no hit, the next state SHALL be DONE, setting done=1, timed_out=1, pass=0 and halt=1. There is no dump.
REQ-008 A hit and a timeout in the same cycle SHALL resolve as a hit.
REQ-009 READ SHALL last one cycle: rd_en=1 and rd_addr=(DUMP_BASE+idx) mod 2^ADDR_W.
REQ-010 WAIT SHALL last one cycle. At its closing edge, rd_data SHALL be registered into dump_data and idx into dump_idx. The FSM then enters PRESENT.
REQ-011 In PRESENT: dump_valid=1, with dump_data and dump_idx held stable until dump_valid&&dump_ready. On that transfer:
- if idx=DUMP_COUNT-1, go to DONE with pass=1;
- otherwise increment idx and go to READ.
REQ-012 Latency SHALL be: dump_valid rises 2 cycles after entering READ; minimum cost 3 cycles per word with dump_ready held high.
REQ-013 With DUMP_COUNT=0, a hit SHALL go directly to DONE with pass=1, and dump_valid never asserts.
REQ-014 rd_en and dump_valid SHALL be 0 outside READ and PRESENT respectively.
REQ-015 After a hit, all dm_* activity SHALL be ignored, including a repeat signature.
REQ-016 DONE SHALL be sticky until rst: done=1 and halt=1; pass and timed_out hold their values; counters stay frozen.
REQ-017 dump_ready is don't-care outside PRESENT.

Reset
REQ-018 While rst=1 at a clock edge: state returns to ARMED, and every output, idx, pc_q, cycle_cnt and instr_cnt go to 0. This applies from any state, including mid-dump.
REQ-019 The first cycle after rst deasserts SHALL count as cycle_cnt=1 at its end.

Verification
REQ-020 Default params; write 0xABCD0000 to addr 20 at cycle 50; dump_ready=1 -> halt=1 at cycle 51; 20 words with dump_idx 0..19 equal to memory 0..19; then done=1, pass=1.
REQ-021 Write 0xABCD0001 to addr 20, then 0xABCD0000 to addr 21 -> no hit; with TIMEOUT=200, done=1, timed_out=1, pass=0 after 200 cycles; rd_en never asserts.
REQ-022 During the dump, dump_ready=0 for 5 cycles in PRESENT -> dump_data and dump_idx unchanged; exactly one transfer when ready rises; no word skipped or duplicated.
REQ-023 rst asserted while PRESENT with idx=7 -> next cycle all outputs 0 and state ARMED; a new signature restarts the dump at idx 0.
REQ-024 TIMEOUT=100; signature written in the cycle where cycle_cnt=99 -> pass path taken, timed_out=0.
REQ-025 pc toggles on 10 cycles, then a hit -> instr_cnt=10 and frozen; DUMP_COUNT=0 -> done=1 and pass=1 one cycle after the hit.
